// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline types, ALU encodings and the bubble control bundle
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;
    localparam logic [3:0] ALU_NOR = 4'hC;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the register a load in EX has yet to produce
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              load_use
);

    assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX stage register with load-use stall, flush bubbles and stall counter
module id_ex_pipeline_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ID_Valid,
    input  logic              ID_RegWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [3:0]        ID_ALUCtrl,
    input  logic [DATA_W-1:0] ID_RD1,
    input  logic [DATA_W-1:0] ID_RD2,
    input  logic [DATA_W-1:0] ID_SignImm,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic              Flush,
    input  logic              Hold,
    output logic              EX_Valid,
    output logic              EX_RegWrite,
    output logic              EX_MemToReg,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_ALUSrc,
    output logic              EX_RegDst,
    output logic [3:0]        EX_ALUCtrl,
    output logic [DATA_W-1:0] EX_RD1,
    output logic [DATA_W-1:0] EX_RD2,
    output logic [DATA_W-1:0] EX_SignImm,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [REG_AW-1:0] EX_Rs,
    output logic [REG_AW-1:0] EX_Rt,
    output logic [REG_AW-1:0] EX_Rd,
    output logic              StallF,
    output logic              StallD,
    output logic [CNT_W-1:0]  LoadUseCnt
);

    ctrl_t             id_ctrl, ctrl_d, ctrl_q;
    logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, pc_d, pc_q;
    logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              load_use, bubble, count;

    assign id_ctrl = {ID_Valid, ID_RegWrite, ID_MemToReg, ID_MemRead,
                      ID_MemWrite, ID_ALUSrc, ID_RegDst, ID_ALUCtrl};

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .ex_valid    (ctrl_q.valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_valid    (ID_Valid),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .load_use    (load_use)
    );

    // Flush wins over everything; Hold freezes the stage; an unflushed load-use inserts a counted bubble
    always_comb begin
        bubble = Flush | (~Hold & load_use);
        count  = ~Flush & ~Hold & load_use & (cnt_q != '1);
        ctrl_d = Hold ? ctrl_q : id_ctrl;
        rd1_d  = Hold ? rd1_q : ID_RD1;
        rd2_d  = Hold ? rd2_q : ID_RD2;
        imm_d  = Hold ? imm_q : ID_SignImm;
        pc_d   = Hold ? pc_q : ID_PCPlus4;
        rs_d   = Hold ? rs_q : ID_Rs;
        rt_d   = Hold ? rt_q : ID_Rt;
        rd_d   = Hold ? rd_q : ID_Rd;
        cnt_d  = count ? cnt_q + CNT_W'(1) : cnt_q;
        if (bubble) begin
            ctrl_d = BUBBLE;
            rd1_d  = '0;
            rd2_d  = '0;
            imm_d  = '0;
            pc_d   = '0;
            rs_d   = '0;
            rt_d   = '0;
            rd_d   = '0;
        end
    end

    // Stage state register; reset leaves a bubble in EX and clears the stall count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_q <= BUBBLE;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign EX_Valid    = ctrl_q.valid;
    assign EX_RegWrite = ctrl_q.reg_write;
    assign EX_MemToReg = ctrl_q.mem_to_reg;
    assign EX_MemRead  = ctrl_q.mem_read;
    assign EX_MemWrite = ctrl_q.mem_write;
    assign EX_ALUSrc   = ctrl_q.alu_src;
    assign EX_RegDst   = ctrl_q.reg_dst;
    assign EX_ALUCtrl  = ctrl_q.alu_ctrl;
    assign EX_RD1      = rd1_q;
    assign EX_RD2      = rd2_q;
    assign EX_SignImm  = imm_q;
    assign EX_PCPlus4  = pc_q;
    assign EX_Rs       = rs_q;
    assign EX_Rt       = rt_q;
    assign EX_Rd       = rd_q;
    assign StallF      = (load_use & ~Flush) | Hold;
    assign StallD      = StallF;
    assign LoadUseCnt  = cnt_q;

endmodule
